// File: rtl/wb_cache_types.sv
// Shared types and constants for the direct-mapped write-back cache.
package wb_cache_types;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned OFFSET_BITS = 5;

    typedef logic [LINE_BITS-1:0] cache_line_t;

endpackage

// File: rtl/wb_cache_array.sv
// Line storage for wb_cache: data and tags read asynchronously, written on the clock;
// valid/dirty bits are the only state cleared by reset.
module wb_cache_array
    import wb_cache_types::*;
#(
    parameter int unsigned S_INDEX = 3
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [S_INDEX-1:0]   index,
    input  logic [31:0]          data_we,
    input  cache_line_t          data_in,
    input  logic                 tag_we,
    input  logic [26-S_INDEX:0]  tag_in,
    input  logic                 valid_set,
    input  logic                 dirty_set,
    input  logic                 dirty_clr,
    output cache_line_t          data_out,
    output logic [26-S_INDEX:0]  tag_out,
    output logic                 valid_out,
    output logic                 dirty_out
);

    localparam int unsigned SETS = 2 ** S_INDEX;

    cache_line_t         data  [SETS];
    logic [26-S_INDEX:0] tags  [SETS];
    logic [SETS-1:0]     valid;
    logic [SETS-1:0]     dirty;

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 32; b++) begin
            if (data_we[b]) begin
                data[index][b*8 +: 8] <= data_in[b*8 +: 8];
            end
        end
        if (tag_we) begin
            tags[index] <= tag_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (valid_set) begin
                valid[index] <= 1'b1;
            end
            if (dirty_clr) begin
                dirty[index] <= 1'b0;
            end else if (dirty_set) begin
                dirty[index] <= 1'b1;
            end
        end
    end

    assign data_out  = data[index];
    assign tag_out   = tags[index];
    assign valid_out = valid[index];
    assign dirty_out = dirty[index];

endmodule

// File: rtl/wb_cache.sv
// Direct-mapped, write-back, write-allocate cache between the CPU and 256-bit memory.
// Optional hit/miss counters are enabled with WB_CACHE_PERF_CNT_EN.
module wb_cache
    import wb_cache_types::*;
#(
    parameter int unsigned S_INDEX = 3
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic         mem_resp,
    output logic [31:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef WB_CACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int unsigned TAG_W = 27 - S_INDEX;

    cache_state_t       state, state_next;
    logic [TAG_W-1:0]   tag, tag_out;
    logic [S_INDEX-1:0] index;
    logic [2:0]         word;
    logic               request, hit, valid_out, dirty_out;
    cache_line_t        data_out, data_in;
    logic [31:0]        data_we;
    logic               tag_we, valid_set, dirty_set, dirty_clr;
    logic [1:0]         unused_addr;

    assign tag         = mem_address[31:OFFSET_BITS+S_INDEX];
    assign index       = mem_address[OFFSET_BITS+S_INDEX-1:OFFSET_BITS];
    assign word        = mem_address[4:2];
    assign unused_addr = mem_address[1:0];
    assign request     = mem_read | mem_write;
    assign hit         = valid_out && (tag_out == tag);

    wb_cache_array #(.S_INDEX(S_INDEX)) u_array (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .data_we   (data_we),
        .data_in   (data_in),
        .tag_we    (tag_we),
        .tag_in    (tag),
        .valid_set (valid_set),
        .dirty_set (dirty_set),
        .dirty_clr (dirty_clr),
        .data_out  (data_out),
        .tag_out   (tag_out),
        .valid_out (valid_out),
        .dirty_out (dirty_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CHECK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        data_we      = '0;
        data_in      = {8{mem_wdata}};
        tag_we       = 1'b0;
        valid_set    = 1'b0;
        dirty_set    = 1'b0;
        dirty_clr    = 1'b0;
        unique case (state)
            CHECK: begin
                if (request && hit) begin
                    mem_resp  = 1'b1;
                    mem_rdata = data_out[{word, 5'b0} +: 32];
                    // a write with no lanes enabled must not mark the line dirty
                    if (mem_write && (mem_byte_enable != 4'b0)) begin
                        data_we   = 32'(mem_byte_enable) << {word, 2'b00};
                        dirty_set = 1'b1;
                    end
                end else if (request) begin
                    state_next = (valid_out && dirty_out) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_out, index, {OFFSET_BITS{1'b0}}};
                pmem_wdata   = data_out;
                if (pmem_resp) begin
                    dirty_clr  = 1'b1;
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                if (pmem_resp) begin
                    data_we    = '1;
                    data_in    = pmem_rdata;
                    tag_we     = 1'b1;
                    valid_set  = 1'b1;
                    dirty_clr  = 1'b1;
                    state_next = CHECK;
                end
            end
            default: state_next = CHECK;
        endcase
    end

`ifdef WB_CACHE_PERF_CNT_EN
    // missed marks a request already counted as a miss so its final response is not a hit
    logic missed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            missed     <= 1'b0;
        end else begin
            if (state == CHECK && request && !hit) begin
                missed <= 1'b1;
                if (miss_count != '1) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
            if (mem_resp) begin
                missed <= 1'b0;
                if (!missed && hit_count != '1) begin
                    hit_count <= hit_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_cache.sv
// Scoreboard bench for wb_cache: directed CPU requests, a latency-2 memory model,
// and decoupled monitors for CPU responses and memory transactions.
module tb_wb_cache;

    typedef struct {
        logic [31:0] data;
        bit          chk;
        int          lat;
        int          start;
    } rexp_t;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } pexp_t;

    localparam int PMEM_LAT = 2;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic         mem_resp;
    logic [31:0]  mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit stray = 0;
    rexp_t rq[$];
    pexp_t pq[$];
    logic [255:0] pm [64];

    wb_cache #(.S_INDEX(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [255:0] fill_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = 32'hA000_0000 | {16'h0, a[15:0]} | 32'(w);
        end
        return l;
    endfunction

    // Memory model: counts request cycles, pulses pmem_resp after PMEM_LAT of them.
    int pcnt = 0;
    always @(negedge clk) begin
        pmem_resp = 1'b0;
        if (!rst) begin
            pcnt = 0;
        end else if (pmem_read || pmem_write) begin
            pcnt++;
            if (pcnt == PMEM_LAT) begin
                pcnt = 0;
                pmem_resp = 1'b1;
                if (pmem_write) pm[pmem_address[10:5]] = pmem_wdata;
                else            pmem_rdata = pm[pmem_address[10:5]];
            end
        end else if (stray) begin
            pmem_resp  = 1'b1;
            pmem_rdata = '1;
        end
    end

    // CPU response monitor
    always @(negedge clk) begin
        rexp_t e;
        if (mem_resp) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: mem_resp=1 addr=%h with nothing outstanding", mem_address);
            end else begin
                e = rq.pop_front();
                if (cyc - e.start != e.lat) begin
                    errors++;
                    $display("FAIL resp_latency addr=%h: got %0d cycles, expected %0d", mem_address, cyc - e.start, e.lat);
                end
                if (e.chk) begin
                    checks++;
                    if (mem_rdata !== e.data) begin
                        errors++;
                        $display("FAIL rdata addr=%h: got %h, expected %h", mem_address, mem_rdata, e.data);
                    end
                end
            end
        end
    end

    // Memory transaction monitor
    logic [1:0] prev_op = 2'b00;
    always @(negedge clk) begin
        logic [1:0] op;
        pexp_t p;
        op = {pmem_write, pmem_read};
        if (op != 2'b00) begin
            checks++;
            if (op == 2'b11 || mem_resp) begin
                errors++;
                $display("FAIL pmem_exclusive: pmem_write=%b pmem_read=%b mem_resp=%b", pmem_write, pmem_read, mem_resp);
            end
        end
        if (op != 2'b00 && op != prev_op) begin
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pmem: op=%b addr=%h", op, pmem_address);
            end else begin
                p = pq.pop_front();
                if (pmem_write !== p.wr || pmem_address !== p.addr) begin
                    errors++;
                    $display("FAIL pmem_req: got write=%b addr=%h, expected write=%b addr=%h", pmem_write, pmem_address, p.wr, p.addr);
                end
                if (p.wr && pmem_wdata !== p.wdata) begin
                    errors++;
                    $display("FAIL pmem_wdata addr=%h: got %h, expected %h", pmem_address, pmem_wdata, p.wdata);
                end
            end
        end
        prev_op = op;
    end

    task automatic expect_pmem(input bit wr, input logic [31:0] addr, input logic [255:0] wdata);
        pexp_t p;
        p.wr = wr; p.addr = addr; p.wdata = wdata;
        pq.push_back(p);
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp, input bit chk, input int lat);
        rexp_t e;
        bit got;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_byte_enable = be; mem_wdata = wd;
        e.data = exp; e.chk = chk; e.lat = lat; e.start = cyc;
        rq.push_back(e);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_resp) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            errors++;
            $display("FAIL resp_timeout addr=%h: no mem_resp within 40 cycles", addr);
            void'(rq.pop_back());
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        logic [255:0] wb_line;
        bit got;
        for (int i = 0; i < 64; i++) pm[i] = fill_line(32'(i) << 5);
        mem_read = 0; mem_write = 0; mem_byte_enable = 0;
        mem_address = 0; mem_wdata = 0; pmem_rdata = '0;
        rst = 1'b1;
        #3 rst = 1'b0;
        #2;
        checks++;
        if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 ||
            mem_rdata !== 32'h0 || pmem_address !== 32'h0 || pmem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: resp=%b pr=%b pw=%b rdata=%h paddr=%h, expected all zero",
                     mem_resp, pmem_read, pmem_write, mem_rdata, pmem_address);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // cold read, then hits
        expect_pmem(0, 32'h40, '0);
        do_req(1, 0, 32'h40, 4'h0, 32'h0, 32'hA000_0040, 1, 3);
        do_req(1, 0, 32'h40, 4'h0, 32'h0, 32'hA000_0040, 1, 0);

        // stray pmem_resp while idle must be ignored
        @(posedge clk); #1 stray = 1;
        @(posedge clk); #1 stray = 0;
        do_req(1, 0, 32'h40, 4'h0, 32'h0, 32'hA000_0040, 1, 0);

        // partial write hit and readback
        do_req(0, 1, 32'h44, 4'b0011, 32'hDEAD_BEEF, 32'h0, 0, 0);
        do_req(1, 0, 32'h44, 4'h0, 32'h0, 32'hA000_BEEF, 1, 0);

        // dirty conflict: writeback 0x40 then fill 0x140
        wb_line = fill_line(32'h40);
        wb_line[63:32] = 32'hA000_BEEF;
        expect_pmem(1, 32'h40, wb_line);
        expect_pmem(0, 32'h140, '0);
        do_req(1, 0, 32'h140, 4'h0, 32'h0, 32'hA000_0140, 1, 5);

        // zero byte-enable write: data unchanged, line stays clean
        do_req(0, 1, 32'h140, 4'b0000, 32'hFFFF_FFFF, 32'h0, 0, 0);
        do_req(1, 0, 32'h140, 4'h0, 32'h0, 32'hA000_0140, 1, 0);
        expect_pmem(0, 32'h40, '0);
        do_req(1, 0, 32'h44, 4'h0, 32'h0, 32'hA000_BEEF, 1, 3);

        // read and write together behave as a write
        do_req(1, 1, 32'h48, 4'b1111, 32'h1234_5678, 32'h0, 0, 0);
        do_req(1, 0, 32'h48, 4'h0, 32'h0, 32'h1234_5678, 1, 0);

        // last set
        expect_pmem(0, 32'hE0, '0);
        do_req(1, 0, 32'hE0, 4'h0, 32'h0, 32'hA000_00E0, 1, 3);
        do_req(0, 1, 32'hFC, 4'b1100, 32'hCAFE_F00D, 32'h0, 0, 0);
        do_req(1, 0, 32'hFC, 4'h0, 32'h0, 32'hCAFE_00E7, 1, 0);
        wb_line = fill_line(32'hE0);
        wb_line[255:224] = 32'hCAFE_00E7;
        expect_pmem(1, 32'hE0, wb_line);
        expect_pmem(0, 32'h1E0, '0);
        do_req(1, 0, 32'h1E0, 4'h0, 32'h0, 32'hA000_01E0, 1, 5);

        // reset in the middle of a fill
        expect_pmem(0, 32'h80, '0);
        @(posedge clk); #1;
        mem_read = 1'b1; mem_address = 32'h80;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pmem_read) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL fill_start: pmem_read never asserted for addr 00000080");
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pr=%b pw=%b resp=%b, expected 0 0 0", pmem_read, pmem_write, mem_resp);
        end
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        expect_pmem(0, 32'h80, '0);
        do_req(1, 0, 32'h80, 4'h0, 32'h0, 32'hA000_0080, 1, 3);
        // dirty line lost by reset: plain refill, no writeback
        expect_pmem(0, 32'h40, '0);
        do_req(1, 0, 32'h40, 4'h0, 32'h0, 32'hA000_0040, 1, 3);

        repeat (3) @(posedge clk);
        checks++;
        if (rq.size() != 0) begin
            errors++;
            $display("FAIL resp_queue: %0d responses outstanding, expected 0", rq.size());
        end
        checks++;
        if (pq.size() != 0) begin
            errors++;
            $display("FAIL pmem_queue: %0d transactions outstanding, expected 0", pq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_cache.md
Name: wb_cache

Overview:
- Direct-mapped, write-back, write-allocate cache.
- Sits directly downstream of the RV32I multicycle CPU core. It consumes the core's word-wide request (read, write, byte enable, address, write data) and returns read data with a response strobe.
- Toward physical memory it issues 256-bit line reads and writebacks over a request/response handshake.

Parameters:
- S_INDEX, 3, set-index bits; number of sets = 2**S_INDEX.
- Line size is fixed at 32 bytes, so offset = 5 bits.
- Tag width = 27 - S_INDEX.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- mem_read  in  1  CPU read request; held high until mem_resp.
- mem_write  in  1  CPU write request; held high until mem_resp.
- mem_byte_enable  in  4  byte lanes for writes.
- mem_address  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  CPU write data.
- mem_resp  out  1  one-cycle completion strobe to the CPU.
- mem_rdata  out  32  read word; valid when mem_resp=1.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  32  line address; bits [4:0] are always 0.
- pmem_wdata  out  256  writeback line.
- pmem_rdata  in  256  fill line.
- pmem_resp  in  1  physical memory done, one cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - All valid and dirty bits cleared; state = CHECK.
  - mem_resp, pmem_read and pmem_write = 0 immediately.
  - mem_rdata, pmem_address and pmem_wdata = 0.
  - Data and tag arrays need not be cleared.
- Address split: tag = addr[31:5+S_INDEX], index = addr[4+S_INDEX:5], word = addr[4:2].
- Request arbitration: request = mem_read | mem_write. If both are high, the access is treated as a write.
- State CHECK (idle):
  - Hit = valid[index] and tag match.
  - Request and hit: mem_resp=1 combinationally in the same cycle; mem_rdata = the selected word of the line.
  - Write hit: at the clock edge, only enabled bytes of the word are updated. Dirty is set only if mem_byte_enable != 0.
  - Stay in CHECK.
  - Request, miss, line valid and dirty: go to WRITEBACK.
  - Request, miss otherwise: go to ALLOCATE.
  - No request: mem_resp=0; no state change.
- State WRITEBACK:
  - pmem_write=1, pmem_address = {stored tag, index, 5'b0}, pmem_wdata = stored line.
  - On pmem_resp: clear dirty, go to ALLOCATE.
- State ALLOCATE:
  - pmem_read=1, pmem_address = {addr[31:5], 5'b0}.
  - On pmem_resp: write pmem_rdata into the line, update the tag, set valid, clear dirty, return to CHECK. The held request then hits.
- Latency:
  - Hit: 0 cycles (response in the request cycle).
  - Clean miss: pmem latency + 1 cycle.
  - Dirty miss: 2 × pmem latency + 1 cycle.
- Boundary conditions:
  - pmem_resp in CHECK is ignored.
  - pmem_read and pmem_write are never high together.
  - mem_resp is never asserted in WRITEBACK or ALLOCATE.
  - Address changes while a miss is in flight are undefined; the CPU guarantees its request is stable.
  - Reset mid-miss abandons the transaction; no partial line is written.
  - Index wrap: the last set (index 2**S_INDEX-1) behaves like any other set.

Optional Feature:
- Macro: WB_CACHE_PERF_CNT_EN.
- When defined:
  - Adds output ports hit_count[31:0] and miss_count[31:0].
  - hit_count increments once per request that completes in CHECK without a prior miss.
  - miss_count increments on each CHECK→WRITEBACK or CHECK→ALLOCATE transition.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package wb_cache_types:
  - State enum cache_state_t {CHECK, WRITEBACK, ALLOCATE}.
  - Constants LINE_BITS=256, OFFSET_BITS=5.
  - Line typedef logic [255:0].
- Sub-module wb_cache_array: storage for data, tag, valid and dirty.
  - Parameterized by S_INDEX.
  - Asynchronous read, synchronous write with a 32-byte enable.
  - Valid/dirty cleared by rst.
- The top level holds the FSM and muxing.

Test Plan:
- Cold read 0x0000_0040 → ALLOCATE issued with pmem_address=0x0000_0040; after pmem_resp, mem_resp=1 and mem_rdata = word 0 of the fill line; a repeat read gives mem_resp in the same cycle with no pmem activity.
- Write 0xDEADBEEF with byte_enable=4'b0011 to hit address 0x44 → subsequent read returns the old upper 16 bits with 0xBEEF in the lower half; dirty set.
- Conflict read 0x0000_0140 (same index as 0x40, S_INDEX=3) while dirty → pmem_write first with address 0x40 and modified data, then pmem_read 0x140.
- Write with byte_enable=0 on a hit → mem_resp=1, data unchanged, a later conflict miss produces no writeback.
- Assert rst=0 during ALLOCATE → pmem_read drops with no clock edge; after release a read of the same address misses again.
- mem_read and mem_write both high → treated as a write; mem_rdata is don't-care.
